// File: rtl/add_pipe_pkg.sv
// add_pipe shared definitions: group width, parameter legality
// and the 4-bit lookahead carry network.
package add_pipe_pkg;

    localparam int GRP_W = 4;

    typedef logic [GRP_W-1:0] grp_t;

    function automatic bit params_ok(int width, int seg);
        return (seg > 0) && (width >= seg) &&
               ((width % seg) == 0) && ((seg % GRP_W) == 0);
    endfunction

    // Carries into each bit of a group plus the group carry-out,
    // expanded as sum-of-products so no bit waits on its neighbour.
    function automatic logic [GRP_W:0] grp_carries(
        grp_t g,
        grp_t p,
        logic cin
    );
        logic [GRP_W:0] c;
        logic           t;
        c = '0;
        for (int j = 0; j <= GRP_W; j++) begin
            t = cin;
            for (int i = 0; i < j; i++) begin
                t = t & p[i];
            end
            c[j] = t;
            for (int i = 0; i < j; i++) begin
                t = g[i];
                for (int m = i + 1; m < j; m++) begin
                    t = t & p[m];
                end
                c[j] = c[j] | t;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle between add_pipe and its
// producer/consumer.
interface add_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_op1;
    logic [WIDTH-1:0] in_op2;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_op1,
        output in_op2,
        output in_sub,
        output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_carry,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_op1,
        input  in_op2,
        input  in_sub,
        input  in_cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_carry,
        output out_ovf
    );

endinterface

// File: rtl/add_pipe_seg_cla.sv
// seg_cla: combinational SEG-bit two-level carry-lookahead adder
// (4-bit group generate/propagate, lookahead across groups).
module seg_cla
    import add_pipe_pkg::*;
#(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    localparam int NG = SEG / GRP_W;

    if ((SEG % GRP_W) != 0 || SEG < GRP_W) begin : g_bad_seg
        $error("seg_cla: SEG must be a positive multiple of %0d", GRP_W);
    end

    logic [SEG-1:0]   g;
    logic [SEG-1:0]   p;
    logic [SEG-1:0]   c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic [GRP_W:0]   tc;
    logic             t;

    always_comb begin
        g   = a & b;
        p   = a ^ b;
        c   = '0;
        gg  = '0;
        gp  = '0;
        gc  = '0;
        tc  = '0;
        t   = 1'b0;

        for (int j = 0; j < NG; j++) begin
            tc    = grp_carries(g[j*GRP_W +: GRP_W], p[j*GRP_W +: GRP_W], 1'b0);
            gg[j] = tc[GRP_W];
            gp[j] = &p[j*GRP_W +: GRP_W];
        end

        // Second level: every group carry straight from group G/P and cin.
        for (int j = 0; j <= NG; j++) begin
            t = cin;
            for (int i = 0; i < j; i++) begin
                t = t & gp[i];
            end
            gc[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) begin
                    t = t & gp[m];
                end
                gc[j] = gc[j] | t;
            end
        end

        for (int j = 0; j < NG; j++) begin
            tc = grp_carries(g[j*GRP_W +: GRP_W], p[j*GRP_W +: GRP_W], gc[j]);
            c[j*GRP_W +: GRP_W] = tc[GRP_W-1:0];
        end
    end

    assign sum   = p ^ c;
    assign cout  = gc[NG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/add_pipe.sv
// add_pipe: pipelined carry-lookahead adder/subtractor, one SEG-bit
// slice per stage with the inter-slice carry registered.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    add_pipe_if.slave io
);

    localparam int NSEG = WIDTH / SEG;
    localparam int NOP  = (NSEG > 1) ? NSEG - 1 : 1;

    if (!params_ok(WIDTH, SEG)) begin : g_bad_param
        $error("add_pipe: WIDTH must be a multiple of SEG and SEG a multiple of %0d",
               GRP_W);
    end

    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    logic [SEG-1:0]   sa [NSEG];
    logic [SEG-1:0]   sb [NSEG];
    logic [SEG-1:0]   ss [NSEG];
    logic [NSEG-1:0]  sc;
    logic [NSEG-1:0]  co;
    logic [NSEG-1:0]  cm;

    logic [NSEG:1]    v_q;
    logic [NSEG:1]    v_d;
    logic [NSEG:1]    cy_q;
    logic [NSEG:1]    cy_d;
    logic [NSEG:1]    cm_q;
    logic [NSEG:1]    cm_d;
    logic [WIDTH-1:0] r_q [1:NSEG];
    logic [WIDTH-1:0] r_d [1:NSEG];
    logic [WIDTH-1:0] a_q [1:NOP];
    logic [WIDTH-1:0] a_d [1:NOP];
    logic [WIDTH-1:0] b_q [1:NOP];
    logic [WIDTH-1:0] b_d [1:NOP];

    assign adv         = !v_q[NSEG] || io.out_ready;
    assign io.in_ready = adv && !flush;

    assign b_in = io.in_sub ? ~io.in_op2 : io.in_op2;
    assign c_in = io.in_sub | io.in_cin;

    // Slice k is fed from the inputs (k=0) or from stage k's registers.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            sa[k] = '0;
            sb[k] = '0;
        end
        sc = '0;
        sa[0] = io.in_op1[SEG-1:0];
        sb[0] = b_in[SEG-1:0];
        sc[0] = c_in;
        for (int k = 1; k < NSEG; k++) begin
            sa[k] = a_q[k][k*SEG +: SEG];
            sb[k] = b_q[k][k*SEG +: SEG];
            sc[k] = cy_q[k];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        seg_cla #(
            .SEG (SEG)
        ) u_cla (
            .a     (sa[k]),
            .b     (sb[k]),
            .cin   (sc[k]),
            .sum   (ss[k]),
            .cout  (co[k]),
            .c_msb (cm[k])
        );
    end

    always_comb begin
        v_d  = v_q;
        cy_d = cy_q;
        cm_d = cm_q;
        r_d  = r_q;
        a_d  = a_q;
        b_d  = b_q;
        if (flush) begin
            v_d = '0;
        end else if (adv) begin
            v_d[1]          = io.in_valid;
            r_d[1]          = '0;
            r_d[1][SEG-1:0] = ss[0];
            cy_d[1]         = co[0];
            cm_d[1]         = cm[0];
            if (NSEG > 1) begin
                a_d[1] = io.in_op1;
                b_d[1] = b_in;
            end
            for (int k = 1; k < NSEG; k++) begin
                v_d[k+1]                = v_q[k];
                r_d[k+1]                = r_q[k];
                r_d[k+1][k*SEG +: SEG]  = ss[k];
                cy_d[k+1]               = co[k];
                cm_d[k+1]               = cm[k];
            end
            for (int k = 1; k < NSEG - 1; k++) begin
                a_d[k+1] = a_q[k];
                b_d[k+1] = b_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            cy_q <= '0;
            cm_q <= '0;
            for (int k = 1; k <= NSEG; k++) begin
                r_q[k] <= '0;
            end
            for (int k = 1; k <= NOP; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            v_q  <= v_d;
            cy_q <= cy_d;
            cm_q <= cm_d;
            r_q  <= r_d;
            a_q  <= a_d;
            b_q  <= b_d;
        end
    end

    assign io.out_valid  = v_q[NSEG];
    assign io.out_result = r_q[NSEG];
    assign io.out_carry  = cy_q[NSEG];
    assign io.out_ovf    = cy_q[NSEG] ^ cm_q[NSEG];

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the multiplier and ALU datapaths.
- Successor to the fixed 64-bit single-cycle lookahead adder. Width is generalised and the operation is split into SEG-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Adds a subtract mode, a signed-overflow flag, valid/ready flow control and a flush input, so wide additions close timing at high clock rates.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of SEG.
- SEG, 16, bits added per stage; must be a multiple of 4.
- NSEG, WIDTH/SEG, number of stages (= latency); derived, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all in-flight operations
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- in_op1  in  WIDTH  operand 1
- in_op2  in  WIDTH  operand 2
- in_sub  in  1  1 = op1 - op2 (op2 inverted, carry-in forced 1)
- in_cin  in  1  carry-in, used only when in_sub=0
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  sum/difference
- out_carry  out  1  carry out of the MSB; for subtract, 1 = no borrow
- out_ovf  out  1  signed overflow

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset:
  - All stage valid bits clear; out_valid=0.
  - out_result, out_carry and out_ovf reset to 0.
  - Datapath registers may also reset to 0.
- Accept: a transaction is accepted when in_valid && in_ready.
- Stage k (k=1..NSEG) contents:
  - valid bit
  - result slices 0..k-1 already computed
  - raw operand slices k..NSEG-1 not yet used (op2 already conditionally inverted)
  - carry into slice k
  - carry into the MSB of slice k-1 (needed for out_ovf)
- Stage 1 computes slice 0 from the inputs, with carry-in = in_sub ? 1 : in_cin. Stage k computes slice k-1 from its carried operand slices and the registered carry.
- Each slice is computed by a SEG-bit lookahead adder with 4-bit group generate/propagate. No ripple across slices within a cycle.
- Output:
  - The last stage register drives out_*.
  - out_valid = valid[NSEG].
  - out_ovf = carry into MSB XOR carry out of MSB.
- Latency: NSEG cycles from accept to out_valid, with no stall.
- Throughput: one transaction per cycle.
- Flow control:
  - adv = !out_valid || out_ready.
  - The whole pipeline shifts when adv is high and holds all registers when adv is low.
  - in_ready = adv, combinational from out_ready. No skid buffer.
  - Bubbles shift through like data. Invalid stages may hold garbage data.
- Ordering: results emerge in acceptance order. No drops or duplicates under any stall pattern.
- flush:
  - Next edge clears every valid bit, including the output stage.
  - in_ready is forced 0 during the flush cycle, so nothing is accepted that cycle.
  - flush has priority over adv.
- Reset asserted mid-operation: all valid bits clear immediately (asynchronous). No output is produced for in-flight transactions.
- Boundaries:
  - Carry out of the top slice appears only as out_carry; nothing wraps into slice 0.
  - With WIDTH=SEG (NSEG=1), the block is a single registered stage.
  - A simultaneous out handshake and in accept with a full pipeline is legal and keeps it full.

Decomposition:
- Shared header add_pipe_defs.vh holds:
  - the 4-bit group generate/propagate width constant
  - a parameter legality check: WIDTH % SEG == 0 and SEG % 4 == 0, with an elaboration-time $error otherwise
- Sub-module seg_cla (parameter SEG): combinational SEG-bit lookahead adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (carry into the MSB).
  - Built from two-level 4-bit group P/G.
- add_pipe instantiates NSEG copies of seg_cla plus the stage registers and control.

Test Plan (WIDTH=64, SEG=16, latency 4):
- Carry chain through all stages:
  - Stimulus: op1=0xFFFF_FFFF_FFFF_FFFF, op2=1, sub=0, cin=0, out_ready=1.
  - Required: out_valid 4 cycles after accept; result=0, carry=1, ovf=0.
- Subtract with borrow:
  - Stimulus: op1=5, op2=7, sub=1.
  - Required: result=0xFFFF_FFFF_FFFF_FFFE, carry=0, ovf=0.
- Signed overflow:
  - Stimulus: op1=0x7FFF_FFFF_FFFF_FFFF, op2=1, sub=0, cin=0.
  - Required: result=0x8000_0000_0000_0000, ovf=1, carry=0.
- Back-pressure:
  - Stimulus: 10 back-to-back random transactions; out_ready held low for cycles 6-9.
  - Required: in_ready low exactly while out_valid && !out_ready; all 10 results match a reference model in order; output held stable while stalled.
- Flush:
  - Stimulus: 3 transactions in flight, flush=1 for one cycle.
  - Required: out_valid=0 the next cycle, no flushed result ever emerges, in_ready=0 during flush; a transaction accepted after flush returns normally 4 cycles later.
- Reset mid-operation:
  - Stimulus: rst_n driven low asynchronously between edges with 2 transactions in flight.
  - Required: out_valid, out_result, out_carry and out_ovf drop to 0 immediately; after release the first new result is correct with latency 4.
